acc_act_pool_core: RTL and testbench
====================================

# acc_act_pool_core

Parametrised successor to the fixed 16-lane accumulate/activate/pool path. It takes per-lane partial sums from the systolic array and accumulates a configurable number of partial sums per output pixel. Each result is requantised, passed through optional ReLU and optional 2x2/stride-2 max-pooling, and emitted under valid/ready to the output buffer writer. Lane count, widths and maximum map size are parameters; pooling and activation are selected per layer.

## Interface
- LANES, 16, parallel output channels (one lane per channel)
- PSUM_W, 8, signed partial-sum width per lane
- ACC_W, 20, signed accumulator width
- DATA_W, 8, signed output width
- MAX_OFMAP, 32, maximum ofmap side length
- MAX_ACC, 64, maximum partial sums per pixel
- One clock; reset is asynchronous and active-low: clk, rst_n
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_i  in  1  pulse; latches config, starts a layer
- ofmap_size_i  in  $clog2(MAX_OFMAP+1)  ofmap side S
- acc_len_i  in  $clog2(MAX_ACC+1)  partial sums per pixel N
- shift_i  in  $clog2(ACC_W)  requant arithmetic right shift
- pool_en_i  in  1  2x2 max-pool enable
- relu_en_i  in  1  ReLU enable
- psum_valid_i  in  1  all lanes carry a psum
- psum_ready_o  out  1  psum accepted when valid&&ready
- psum_i  in  [LANES][PSUM_W]  lane psums, same pixel/step
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  [LANES][DATA_W]  lane results
- out_addr_o  out  $clog2(MAX_OFMAP*MAX_OFMAP)  output pixel index
- out_last_o  out  1  final output of layer
- busy_o  out  1  layer in progress
- done_o  out  1  one-cycle pulse at layer end

## Operation
- FSM IDLE -> RUN -> FLUSH -> IDLE. start_i in IDLE latches config and enters RUN. start_i outside IDLE is ignored. S==0 or N==0: FLUSH directly, done_o with no output.
- RUN: counters step (step 0..N-1), col, row. acc = sext(psum) at step 0, acc + sext(psum) otherwise; wraps modulo 2^ACC_W. After the step-N-1 beat the pixel completes and col/row advance in raster order.
- Requant: acc >>> shift_i (floor), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; ReLU maps negatives to 0.
- Pool off: every pixel is output; addr = row*S+col.
- Pool on, per lane: hreg and line buffer lb[MAX_OFMAP/2].
  - Even row: even col -> hreg=px; odd col -> lb[col/2]=max(hreg,px).
  - Odd row: even col -> hreg=px; odd col -> output max(lb[col/2],hreg,px), addr=(row/2)*(S/2)+col/2.
  - All comparisons are signed.
  - Odd S: last row/col are consumed but never output. S==1 gives no output.
- out_last_o is set on the final output of the layer. After the last pixel completes, go to FLUSH. Leave FLUSH when no output is pending, then pulse done_o and return to IDLE.

## Timing
- Reset: out_valid_o=0, out_data_o=0, out_addr_o=0, out_last_o=0, busy_o=0, done_o=0, psum_ready_o=0, FSM IDLE, counters 0.
- busy_o=1 from the cycle after start_i until the done_o cycle inclusive. psum_ready_o=0 outside RUN.
- psum_ready_o = RUN && (!out_valid_o || out_ready_i). No skid buffer; a full output register stalls input.
- Final beat of a pixel accepted at cycle t: any output it produces has out_valid_o=1 at t+1.
- out_valid_o/data/addr/last stay stable until out_ready_i. Fill and drain of the output register in the same cycle is allowed.
- done_o fires the cycle after the last output handshake, or the cycle after the last pixel if that pixel produces no output.
- rst_n low mid-layer aborts immediately. Line buffer contents need no clearing.

## Structure
- Package acp_pkg holds:
  - state enum {IDLE, RUN, FLUSH}
  - config struct (S, N, shift, pool_en, relu_en)
  - function sat_relu(acc, shift, relu) -> DATA_W
- Sub-module acp_lane: accumulator, requant, hreg, lb, max logic. Generated LANES times.
- Top level: FSM, shared counters, address generation, output register, handshake.

## Test plan
- S=4, N=2, shift=0, pool+ReLU. Lane0 pixel k sums to k+1 (beats (k+1,0)). -> outputs 6,8,14,16 at addr 0..3; out_last_o with 16; done_o next cycle.
- S=2, N=3, pool off. Lane1 beats 127,127,127. -> 127 saturated. Lane2 beats -100,0,0, relu off -> -100; relu on -> 0.
- N=1, shift=2, psum -5 -> -2 (floor). psum 7 -> 1.
- S=4, pool off, out_ready_i low 5 cycles after first output. -> psum_ready_o low, data/addr held; all 16 outputs in order, none lost.
- S=3, pool on. -> exactly one output, max of pixels 0,1,3,4, addr 0, out_last_o=1; done_o after pixel 8.
- start_i pulsed mid-RUN -> ignored. rst_n low mid-layer -> all outputs 0 at once; new start_i runs clean.

Source files
------------

// File: rtl/acp_pkg.sv
// Shared types and requantisation helper for the accumulate/activate/pool core.
package acp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Per-layer configuration, latched on start. Fields are wide enough for any legal parameter set.
  typedef struct packed {
    logic [15:0] s;
    logic [15:0] n;
    logic [7:0]  shift;
    logic        pool_en;
    logic        relu_en;
  } cfg_t;

  // Floor shift, saturate to a signed data_w range, then optional ReLU.
  function automatic logic signed [31:0] sat_relu(
    input logic signed [63:0] acc,
    input int unsigned        shift,
    input logic               relu,
    input int unsigned        data_w = 8
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi) sh = hi;
    else if (sh < lo) sh = lo;
    if (relu && sh < 64'sd0) sh = 64'sd0;
    return sh[31:0];
  endfunction

endpackage

// File: rtl/acp_lane.sv
// One channel: accumulate psums, requantise, 2x2 max-pool via hreg and a half-row line buffer.
// Latency: combinational result in the cycle of the final psum beat.
// Backpressure: none locally; the top only asserts beat when the output register can take it.
module acp_lane
  import acp_pkg::*;
#(
  parameter int PSUM_W    = 8,
  parameter int ACC_W     = 20,
  parameter int DATA_W    = 8,
  parameter int MAX_OFMAP = 32,
  parameter int LB_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat,
  input  logic              first,
  input  logic              pix_done,
  input  logic              pool_en,
  input  logic              relu_en,
  input  logic              row_odd,
  input  logic              col_odd,
  input  logic [7:0]        shift,
  input  logic [LB_W-1:0]   lb_idx,
  input  logic [PSUM_W-1:0] psum,
  output logic [DATA_W-1:0] res
);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [DATA_W-1:0] px;
  logic signed [DATA_W-1:0] hreg;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] lb [MAX_OFMAP/2];

  assign psum_ext = ACC_W'($signed(psum));
  assign acc_nxt  = first ? psum_ext : acc + psum_ext;
  assign px       = DATA_W'(sat_relu(64'(acc_nxt), 32'(shift), relu_en, DATA_W));
  assign lb_rd    = lb[lb_idx];
  assign hmax     = (hreg > px) ? hreg : px;

  always_comb begin
    res = px;
    if (pool_en) res = (lb_rd > hmax) ? lb_rd : hmax;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      hreg <= '0;
    end else begin
      if (beat) acc <= acc_nxt;
      if (pix_done && !col_odd) hreg <= px;
    end
  end

  // Line buffer holds the horizontal max of each even-row pair; stale contents are never read.
  always_ff @(posedge clk) begin
    if (pix_done && col_odd && !row_odd) lb[lb_idx] <= hmax;
  end

endmodule

// File: rtl/acc_act_pool_core.sv
// Accumulate/requantise/ReLU/2x2-maxpool over LANES channels, raster-ordered output with addresses.
// Latency: result registered one cycle after the final psum beat of a pixel.
// Backpressure: psum_ready_o drops while the single output register is full and not draining.
module acc_act_pool_core
  import acp_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int PSUM_W    = 8,
  parameter int ACC_W     = 20,
  parameter int DATA_W    = 8,
  parameter int MAX_OFMAP = 32,
  parameter int MAX_ACC   = 64,
  localparam int S_W      = $clog2(MAX_OFMAP + 1),
  localparam int N_W      = $clog2(MAX_ACC + 1),
  localparam int SH_W     = $clog2(ACC_W),
  localparam int A_W      = $clog2(MAX_OFMAP * MAX_OFMAP),
  localparam int LB_W     = (MAX_OFMAP > 2) ? $clog2(MAX_OFMAP / 2) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [S_W-1:0]                ofmap_size_i,
  input  logic [N_W-1:0]                acc_len_i,
  input  logic [SH_W-1:0]               shift_i,
  input  logic                          pool_en_i,
  input  logic                          relu_en_i,
  input  logic                          psum_valid_i,
  output logic                          psum_ready_o,
  input  logic [LANES-1:0][PSUM_W-1:0]  psum_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [LANES-1:0][DATA_W-1:0]  out_data_o,
  output logic [A_W-1:0]                out_addr_o,
  output logic                          out_last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  state_t      state;
  cfg_t        cfg;
  logic [15:0] step;
  logic [15:0] col;
  logic [15:0] row;
  logic [15:0] s_even;
  logic        beat;
  logic        last_step;
  logic        last_col;
  logic        last_row;
  logic        pix_done;
  logic        last_pixel;
  logic        emit;
  logic        emit_last;
  logic [LANES-1:0][DATA_W-1:0] lane_res;

  assign psum_ready_o = (state == RUN) && (!out_valid_o || out_ready_i);
  assign beat         = psum_valid_i && psum_ready_o;
  assign last_step    = step == cfg.n - 16'd1;
  assign last_col     = col == cfg.s - 16'd1;
  assign last_row     = row == cfg.s - 16'd1;
  assign pix_done     = beat && last_step;
  assign last_pixel   = pix_done && last_col && last_row;
  assign s_even       = {cfg.s[15:1], 1'b0};
  // Pooled outputs only appear at the bottom-right pixel of each complete 2x2 window.
  assign emit         = pix_done && (!cfg.pool_en || (row[0] && col[0]));
  assign emit_last    = cfg.pool_en ? (row == s_even - 16'd1 && col == s_even - 16'd1)
                                    : (last_col && last_row);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    acp_lane #(
      .PSUM_W    (PSUM_W),
      .ACC_W     (ACC_W),
      .DATA_W    (DATA_W),
      .MAX_OFMAP (MAX_OFMAP),
      .LB_W      (LB_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .beat     (beat),
      .first    (step == 16'd0),
      .pix_done (pix_done),
      .pool_en  (cfg.pool_en),
      .relu_en  (cfg.relu_en),
      .row_odd  (row[0]),
      .col_odd  (col[0]),
      .shift    (cfg.shift),
      .lb_idx   (LB_W'(col >> 1)),
      .psum     (psum_i[g]),
      .res      (lane_res[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cfg    <= '0;
      step   <= '0;
      col    <= '0;
      row    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          if (start_i) begin
            cfg    <= '{s: 16'(ofmap_size_i), n: 16'(acc_len_i), shift: 8'(shift_i),
                        pool_en: pool_en_i, relu_en: relu_en_i};
            step   <= '0;
            col    <= '0;
            row    <= '0;
            busy_o <= 1'b1;
            state  <= (ofmap_size_i == '0 || acc_len_i == '0) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (last_step) begin
              step <= '0;
              if (last_col) begin
                col <= '0;
                row <= row + 16'd1;
              end else begin
                col <= col + 16'd1;
              end
            end else begin
              step <= step + 16'd1;
            end
            // A final pixel with nothing to emit has no pending output, so finish at once.
            if (last_pixel) begin
              if (emit) begin
                state <= FLUSH;
              end else begin
                state  <= IDLE;
                done_o <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (!out_valid_o || out_ready_i) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (emit) begin
      out_valid_o <= 1'b1;
      out_data_o  <= lane_res;
      out_last_o  <= emit_last;
      out_addr_o  <= cfg.pool_en ? A_W'(32'(row >> 1) * 32'(cfg.s >> 1) + 32'(col >> 1))
                                 : A_W'(32'(row) * 32'(cfg.s) + 32'(col));
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_act_pool_core.sv
// Directed bench for acc_act_pool_core with hand-computed expectations.
module tb_acc_act_pool_core;

  localparam int LANES  = 16;
  localparam int PSUM_W = 8;
  localparam int DATA_W = 8;

  typedef logic [LANES-1:0][PSUM_W-1:0] vec_t;
  typedef logic [LANES-1:0][DATA_W-1:0] ovec_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  ofmap_size_i;
  logic [6:0]  acc_len_i;
  logic [4:0]  shift_i;
  logic        pool_en_i;
  logic        relu_en_i;
  logic        psum_valid_i;
  logic        psum_ready_o;
  vec_t        psum_i;
  logic        out_valid_o;
  logic        out_ready_i;
  ovec_t       out_data_o;
  logic [9:0]  out_addr_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acyc;

  ovec_t      q_data[$];
  logic [9:0] q_addr[$];
  logic       q_last[$];
  int         q_cyc[$];
  int         done_cyc[$];

  acc_act_pool_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .ofmap_size_i (ofmap_size_i),
    .acc_len_i    (acc_len_i),
    .shift_i      (shift_i),
    .pool_en_i    (pool_en_i),
    .relu_en_i    (relu_en_i),
    .psum_valid_i (psum_valid_i),
    .psum_ready_o (psum_ready_o),
    .psum_i       (psum_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_addr_o   (out_addr_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record output handshakes and done pulses mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      q_data.push_back(out_data_o);
      q_addr.push_back(out_addr_o);
      q_last.push_back(out_last_o);
      q_cyc.push_back(cyc);
    end
    if (done_o) done_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3);
    vec_t v;
    v    = '0;
    v[0] = a0;
    v[1] = a1;
    v[2] = a2;
    v[3] = a3;
    return v;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_addr.delete();
    q_last.delete();
    q_cyc.delete();
    done_cyc.delete();
  endtask

  // Called just after a rising edge; returns one cycle later with start deasserted.
  task automatic start(input int s, input int n, input int sh, input logic pool, input logic relu);
    ofmap_size_i = 6'(s);
    acc_len_i    = 7'(n);
    shift_i      = 5'(sh);
    pool_en_i    = pool;
    relu_en_i    = relu;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic beat(input vec_t v, output int acc_at);
    logic got;
    got          = 1'b0;
    acc_at       = -1;
    psum_i       = v;
    psum_valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (psum_ready_o) begin
        got    = 1'b1;
        acc_at = cyc;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    psum_valid_i = 1'b0;
    if (!got) check("beat_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && done_cyc.size() == 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("done_seen", 32'(done_cyc.size()), 32'd1);
  endtask

  initial begin
    int exp1 [4];
    exp1 = '{6, 8, 14, 16};
    rst_n        = 1'b0;
    start_i      = 1'b0;
    ofmap_size_i = '0;
    acc_len_i    = '0;
    shift_i      = '0;
    pool_en_i    = 1'b0;
    relu_en_i    = 1'b0;
    psum_valid_i = 1'b0;
    psum_i       = '0;
    out_ready_i  = 1'b1;

    // Reset state
    #13;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", 32'(out_data_o != '0), 32'd0);
    check("rst_addr", 32'(out_addr_o), 32'd0);
    check("rst_last", 32'(out_last_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ready", 32'(psum_ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(psum_ready_o), 32'd0);

    // S=4 N=2 pool+ReLU: window maxima 6,8,14,16
    clear_q();
    start(4, 2, 0, 1'b1, 1'b1);
    check("t1_busy", 32'(busy_o), 32'd1);
    for (int k = 0; k < 16; k++) begin
      beat(mk(8'(k + 1), 8'd0, 8'd0, 8'd0), acyc);
      beat(mk(8'd0, 8'd0, 8'd0, 8'd0), acyc);
    end
    wait_done();
    check("t1_busy_after", 32'(busy_o), 32'd0);
    check("t1_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", 32'(q_data[i][0]), 32'(exp1[i]));
      check("t1_addr", 32'(q_addr[i]), 32'(i));
      check("t1_last", 32'(q_last[i]), 32'(i == 3));
    end
    check("t1_lane1", 32'(q_data[0][1]), 32'd0);
    check("t1_done_time", 32'(done_cyc[0]), 32'(q_cyc[3] + 1));

    // S=2 N=3 pool off ReLU off: saturation both ways, negative passes through
    clear_q();
    start(2, 3, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(mk(8'h80, 8'd127, 8'h9C, 8'd0), acyc);
      beat(mk(8'h80, 8'd127, 8'd0, 8'd0), acyc);
      beat(mk(8'h80, 8'd127, 8'd0, 8'd0), acyc);
    end
    wait_done();
    check("t2_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_lane0_negsat", 32'(q_data[i][0]), 32'h80);
      check("t2_lane1_possat", 32'(q_data[i][1]), 32'h7F);
      check("t2_lane2_neg", 32'(q_data[i][2]), 32'h9C);
      check("t2_addr", 32'(q_addr[i]), 32'(i));
    end
    check("t2_last", 32'(q_last[3]), 32'd1);

    // Same with ReLU on
    clear_q();
    start(2, 3, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      beat(mk(8'h80, 8'd127, 8'h9C, 8'd0), acyc);
      beat(mk(8'h80, 8'd127, 8'd0, 8'd0), acyc);
      beat(mk(8'h80, 8'd127, 8'd0, 8'd0), acyc);
    end
    wait_done();
    check("t2r_count", 32'(q_data.size()), 32'd4);
    check("t2r_lane0", 32'(q_data[0][0]), 32'd0);
    check("t2r_lane1", 32'(q_data[0][1]), 32'h7F);
    check("t2r_lane2", 32'(q_data[0][2]), 32'd0);

    // S=1 N=1 shift=2: floor division of -5 and 7
    clear_q();
    start(1, 1, 2, 1'b0, 1'b0);
    beat(mk(8'hFB, 8'd7, 8'd0, 8'd0), acyc);
    wait_done();
    check("t3_count", 32'(q_data.size()), 32'd1);
    check("t3_neg_floor", 32'(q_data[0][0]), 32'hFE);
    check("t3_pos", 32'(q_data[0][1]), 32'h01);
    check("t3_addr", 32'(q_addr[0]), 32'd0);
    check("t3_last", 32'(q_last[0]), 32'd1);

    // S=4 N=1 pool off with a 5-cycle output stall after the first result
    clear_q();
    start(4, 1, 0, 1'b0, 1'b0);
    beat(mk(8'd0, 8'd0, 8'd0, 8'd0), acyc);
    out_ready_i  = 1'b0;
    psum_i       = mk(8'd1, 8'd0, 8'd0, 8'd0);
    psum_valid_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t4_stall_ready", 32'(psum_ready_o), 32'd0);
      check("t4_stall_valid", 32'(out_valid_o), 32'd1);
      check("t4_stall_data", 32'(out_data_o[0]), 32'd0);
      check("t4_stall_addr", 32'(out_addr_o), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    for (int k = 1; k < 16; k++) beat(mk(8'(k), 8'd0, 8'd0, 8'd0), acyc);
    wait_done();
    check("t4_count", 32'(q_data.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t4_data", 32'(q_data[i][0]), 32'(i));
      check("t4_addr", 32'(q_addr[i]), 32'(i));
    end
    check("t4_last14", 32'(q_last[14]), 32'd0);
    check("t4_last15", 32'(q_last[15]), 32'd1);

    // S=3 pool on: single window of pixels 0,1,3,4 with signed values
    clear_q();
    start(3, 1, 0, 1'b1, 1'b0);
    beat(mk(8'hFB, 8'd10, 8'd0, 8'd0), acyc);
    beat(mk(8'hFD, 8'd20, 8'd0, 8'd0), acyc);
    beat(mk(8'd9,  8'd99, 8'd0, 8'd0), acyc);
    beat(mk(8'hF9, 8'd40, 8'd0, 8'd0), acyc);
    beat(mk(8'hFE, 8'd15, 8'd0, 8'd0), acyc);
    beat(mk(8'd9,  8'd99, 8'd0, 8'd0), acyc);
    beat(mk(8'd50, 8'd99, 8'd0, 8'd0), acyc);
    beat(mk(8'd50, 8'd99, 8'd0, 8'd0), acyc);
    beat(mk(8'd50, 8'd99, 8'd0, 8'd0), acyc);
    wait_done();
    check("t5_count", 32'(q_data.size()), 32'd1);
    check("t5_lane0", 32'(q_data[0][0]), 32'hFE);
    check("t5_lane1", 32'(q_data[0][1]), 32'd40);
    check("t5_addr", 32'(q_addr[0]), 32'd0);
    check("t5_last", 32'(q_last[0]), 32'd1);
    check("t5_done_time", 32'(done_cyc[0]), 32'(acyc + 1));

    // start pulsed mid-layer must be ignored
    clear_q();
    start(2, 1, 0, 1'b0, 1'b0);
    beat(mk(8'd1, 8'd0, 8'd0, 8'd0), acyc);
    start(4, 1, 0, 1'b1, 1'b1);
    beat(mk(8'd2, 8'd0, 8'd0, 8'd0), acyc);
    beat(mk(8'd3, 8'd0, 8'd0, 8'd0), acyc);
    beat(mk(8'd4, 8'd0, 8'd0, 8'd0), acyc);
    wait_done();
    check("t6_count", 32'(q_data.size()), 32'd4);
    check("t6_data", 32'(q_data[3][0]), 32'd4);
    check("t6_addr", 32'(q_addr[3]), 32'd3);
    check("t6_last", 32'(q_last[3]), 32'd1);

    // Reset mid-layer with an output pending, then a clean layer
    clear_q();
    start(2, 1, 0, 1'b0, 1'b0);
    out_ready_i = 1'b0;
    beat(mk(8'd33, 8'd0, 8'd0, 8'd0), acyc);
    check("t7_pending", 32'(out_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(out_valid_o), 32'd0);
    check("t7_rst_data", 32'(out_data_o != '0), 32'd0);
    check("t7_rst_addr", 32'(out_addr_o), 32'd0);
    check("t7_rst_busy", 32'(busy_o), 32'd0);
    check("t7_rst_ready", 32'(psum_ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    start(2, 2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(mk(8'(k + 2), 8'd0, 8'd0, 8'd0), acyc);
      beat(mk(8'd3, 8'd0, 8'd0, 8'd0), acyc);
    end
    wait_done();
    check("t8_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t8_data", 32'(q_data[i][0]), 32'(i + 5));
      check("t8_addr", 32'(q_addr[i]), 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
